// File: rtl/dlx_pipe_pkg.sv
// rtl/dlx_pipe_pkg.sv - shared DLX pipeline widths, NOP encoding and width helper
package dlx_pipe_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  // Also used by decode to squash an instruction popped during a flush
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h54000000;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// rtl/fetch_queue_mem.sv - fetch queue storage, one sync write port, one async read port
module fetch_queue_mem #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode decoupling FIFO with NOP bubble and one-cycle flush
module fetch_queue
  import dlx_pipe_pkg::*;
#(
  parameter int                 DEPTH     = 4,
  parameter logic [INSTR_W-1:0] NOP_INSTR = dlx_pipe_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [INSTR_W-1:0]    enq_instr,
  input  logic [PC_W-1:0]       enq_pc8,
  output logic                  deq_valid,
  input  logic                  deq_ready,
  output logic [INSTR_W-1:0]    deq_instr,
  output logic [PC_W-1:0]       deq_pc8,
  output logic [clog2(DEPTH):0] count
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic [INSTR_W+PC_W-1:0] rdata;

  // Occupancy alone decides full/empty, so the pointers may wrap freely
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = enq_valid & ~full;
  assign pop   = ~empty & deq_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  fetch_queue_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W),
    .DATA_W (INSTR_W + PC_W)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr),
    .wdata ({enq_instr, enq_pc8}),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign enq_ready = ~full;
  assign deq_valid = ~empty;
  assign deq_instr = empty ? NOP_INSTR : rdata[INSTR_W+PC_W-1:PC_W];
  assign deq_pc8   = empty ? '0 : rdata[PC_W-1:0];

endmodule
